// File: rtl/spi_pkg.sv
// Shared constants and FSM state encoding for the SPI responder.
package spi_pkg;

  localparam int unsigned CMD_BITS   = 8;
  localparam int unsigned BYTE_CNT_W = 12;
  localparam logic [CMD_BITS-1:0] RD_CMD_DEF = 8'h03;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA_RX,
    DATA_TX
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer plus history flop; emits registered rise/fall strobes
// aligned with the history-stage level (3 clk from pin to strobe).
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, hist_q, rise_q, fall_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      hist_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      hist_q <= sync_q;
      rise_q <= sync_q & ~hist_q;
      fall_q <= ~sync_q & hist_q;
    end
  end

  assign level_o = hist_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder: cmd byte, address, then data bytes in (write) or out (read).
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned         ADDR_WIDTH = 24,
  parameter logic [CMD_BITS-1:0] RD_CMD     = RD_CMD_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sck,
  input  logic                  spi_cs,
  input  logic                  spi_sdi,
  output logic                  spi_sdo,
  output logic                  spi_sdo_oe,
  output logic                  busy,
  output logic                  cmd_vld,
  output logic [CMD_BITS-1:0]   cmd,
  output logic                  addr_vld,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  rx_vld,
  output logic [7:0]            rx_data,
  output logic                  tx_req,
  input  logic [7:0]            tx_data,
  output logic [BYTE_CNT_W-1:0] byte_cnt,
  output logic                  frame_done
);

  localparam int unsigned BIT_CNT_W = 6;

  logic sck_rise, sck_fall, cs_rise, cs_fall, sdi_lvl;
  logic sck_lvl_unused, cs_lvl_unused, sdi_rise_unused, sdi_fall_unused;

  // CS chain resets low: after any reset CS must be seen high before a frame can start.
  spi_sync_edge u_sync_sck (.clk(clk), .rst(rst), .d_i(spi_sck), .level_o(sck_lvl_unused),
                            .rise_o(sck_rise), .fall_o(sck_fall));
  spi_sync_edge u_sync_cs  (.clk(clk), .rst(rst), .d_i(spi_cs), .level_o(cs_lvl_unused),
                            .rise_o(cs_rise), .fall_o(cs_fall));
  spi_sync_edge u_sync_sdi (.clk(clk), .rst(rst), .d_i(spi_sdi), .level_o(sdi_lvl),
                            .rise_o(sdi_rise_unused), .fall_o(sdi_fall_unused));

  spi_state_e            state_q, state_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [ADDR_WIDTH-1:0] sh_q, sh_d, sh_in;
  logic [CMD_BITS-1:0]   cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            rx_data_q, rx_data_d, tx_sh_q, tx_sh_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic sdo_q, sdo_d, oe_q, oe_d, busy_q, busy_d, tx_ld_q;
  logic cmd_vld_q, cmd_vld_d, addr_vld_q, addr_vld_d, rx_vld_q, rx_vld_d;
  logic tx_req_q, tx_req_d, frame_done_q, frame_done_d;

  assign sh_in = {sh_q[ADDR_WIDTH-2:0], sdi_lvl};

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    sh_d         = sh_q;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    rx_data_d    = rx_data_q;
    tx_sh_d      = tx_sh_q;
    byte_cnt_d   = byte_cnt_q;
    sdo_d        = sdo_q;
    cmd_vld_d    = 1'b0;
    addr_vld_d   = 1'b0;
    rx_vld_d     = 1'b0;
    tx_req_d     = 1'b0;
    frame_done_d = 1'b0;

    // User byte arrives one clk after tx_req; the next sck_fall is always later.
    if (tx_ld_q) tx_sh_d = tx_data;

    if (cs_rise) begin
      if (state_q != IDLE) begin
        state_d      = IDLE;
        frame_done_d = 1'b1;
        sdo_d        = 1'b0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_d    = CMD;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            sdo_d      = 1'b0;
          end
        end
        CMD: begin
          if (sck_rise) begin
            sh_d = sh_in;
            if (bit_cnt_q == BIT_CNT_W'(CMD_BITS - 1)) begin
              cmd_d     = sh_in[CMD_BITS-1:0];
              cmd_vld_d = 1'b1;
              bit_cnt_d = '0;
              state_d   = ADDR;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end
          end
        end
        ADDR: begin
          if (sck_rise) begin
            sh_d = sh_in;
            if (bit_cnt_q == BIT_CNT_W'(ADDR_WIDTH - 1)) begin
              addr_d     = sh_in;
              addr_vld_d = 1'b1;
              bit_cnt_d  = '0;
              if (cmd_q == RD_CMD) begin
                tx_req_d = 1'b1;
                state_d  = DATA_TX;
              end else begin
                state_d  = DATA_RX;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end
          end
        end
        DATA_RX: begin
          if (sck_rise) begin
            sh_d = sh_in;
            if (bit_cnt_q == BIT_CNT_W'(7)) begin
              rx_data_d = sh_in[7:0];
              rx_vld_d  = 1'b1;
              bit_cnt_d = '0;
              if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end
          end
        end
        DATA_TX: begin
          if (sck_fall) begin
            sdo_d   = tx_sh_q[7];
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
          end else if (sck_rise) begin
            if (bit_cnt_q == BIT_CNT_W'(7)) begin
              tx_req_d  = 1'b1;
              bit_cnt_d = '0;
              if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
    oe_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      sh_q         <= '0;
      cmd_q        <= '0;
      addr_q       <= '0;
      rx_data_q    <= '0;
      tx_sh_q      <= '0;
      byte_cnt_q   <= '0;
      sdo_q        <= 1'b0;
      oe_q         <= 1'b0;
      busy_q       <= 1'b0;
      tx_ld_q      <= 1'b0;
      cmd_vld_q    <= 1'b0;
      addr_vld_q   <= 1'b0;
      rx_vld_q     <= 1'b0;
      tx_req_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      sh_q         <= sh_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      rx_data_q    <= rx_data_d;
      tx_sh_q      <= tx_sh_d;
      byte_cnt_q   <= byte_cnt_d;
      sdo_q        <= sdo_d;
      oe_q         <= oe_d;
      busy_q       <= busy_d;
      tx_ld_q      <= tx_req_q;
      cmd_vld_q    <= cmd_vld_d;
      addr_vld_q   <= addr_vld_d;
      rx_vld_q     <= rx_vld_d;
      tx_req_q     <= tx_req_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign spi_sdo    = sdo_q;
  assign spi_sdo_oe = oe_q;
  assign busy       = busy_q;
  assign cmd_vld    = cmd_vld_q;
  assign cmd        = cmd_q;
  assign addr_vld   = addr_vld_q;
  assign addr       = addr_q;
  assign rx_vld     = rx_vld_q;
  assign rx_data    = rx_data_q;
  assign tx_req     = tx_req_q;
  assign byte_cnt   = byte_cnt_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed + randomized frames against spi_slave; a bit-level SPI master and a
// pulse logger feed expectations computed from the frame contents.
module tb_spi_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_sck = 1'b0, spi_cs = 1'b1, spi_sdi = 1'b0;
  logic        spi_sdo, spi_sdo_oe, busy, cmd_vld, addr_vld, rx_vld, tx_req, frame_done;
  logic [7:0]  cmd, rx_data;
  logic [7:0]  tx_data = 8'h00;
  logic [23:0] addr;
  logic [11:0] byte_cnt;

  int total = 0;
  int bad   = 0;

  logic [7:0]  wr_bytes [64];
  logic        sdo_log  [512];
  logic [7:0]  tx_src   [256];
  int          tx_rd_idx = 0;
  logic [7:0]  cmd_log  [64];
  logic [23:0] addr_log [64];
  logic [11:0] bc_log   [64];
  logic [7:0]  rx_log   [256];
  int n_cmd = 0, n_addr = 0, n_rx = 0, n_txreq = 0, n_fd = 0, n_busy = 0, n_both = 0;

  always #5 clk = ~clk;

  spi_slave dut (
    .clk(clk), .rst(rst_n), .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_sdi(spi_sdi),
    .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe), .busy(busy), .cmd_vld(cmd_vld), .cmd(cmd),
    .addr_vld(addr_vld), .addr(addr), .rx_vld(rx_vld), .rx_data(rx_data), .tx_req(tx_req),
    .tx_data(tx_data), .byte_cnt(byte_cnt), .frame_done(frame_done)
  );

  // Pulse logger and transmit-byte user, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (cmd_vld) begin cmd_log[n_cmd] = cmd; bc_log[n_cmd] = byte_cnt; n_cmd++; end
    if (addr_vld) begin addr_log[n_addr] = addr; n_addr++; end
    if (addr_vld && tx_req) n_both++;
    if (rx_vld) begin rx_log[n_rx] = rx_data; n_rx++; end
    if (frame_done) n_fd++;
    if (busy) n_busy++;
    if (tx_req) begin tx_data = tx_src[tx_rd_idx]; tx_rd_idx++; n_txreq++; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Bit-level master: 12.5 MHz SCK, sdi changes on the falling edge, sdo sampled at rise.
  task automatic spi_frame(input logic [7:0] c, input logic [23:0] a, input int nbytes,
                           input int stop_bits, input int rst_bit);
    int   nbits;
    logic b;
    nbits = (stop_bits >= 0) ? stop_bits : 32 + 8 * nbytes;
    @(posedge clk); #3;
    spi_cs = 1'b0; #40;
    for (int i = 0; i < nbits; i++) begin
      if (i < 8)       b = c[7-i];
      else if (i < 32) b = a[31-i];
      else             b = wr_bytes[(i-32)/8][7-((i-32)%8)];
      spi_sdi = b;
      if (i == rst_bit) begin #10 rst_n = 1'b0; #20 rst_n = 1'b1; #10; end
      else #40;
      sdo_log[i] = spi_sdo;
      spi_sck = 1'b1; #40;
      spi_sck = 1'b0;
    end
    #40 spi_cs = 1'b1; #40;
  endtask

  task automatic fill_wr(input int n, input logic fixed, input logic [7:0] val);
    for (int j = 0; j < n; j++) wr_bytes[j] = fixed ? val : 8'($urandom_range(0, 255));
  endtask

  // Expected rx bytes are exactly the data bytes the master sent.
  task automatic chk_rx(input string tag, input int base, input int n);
    for (int j = 0; j < n; j++) chk(tag, 32'(rx_log[base+j]), 32'(wr_bytes[j]));
  endtask

  initial begin
    int b_cmd, b_addr, b_rx, b_tx, b_fd, b_busy, b_both, tbase, nb;
    logic [7:0]  c, c2;
    logic [23:0] a, a2;
    logic [31:0] v;

    for (int j = 0; j < 256; j++) tx_src[j] = 8'h00;

    // Reset state
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_oe", 32'(spi_sdo_oe), 0);
    chk("rst_sdo", 32'(spi_sdo), 0);
    chk("rst_cmd_addr", {cmd, addr}, 0);
    chk("rst_pulses", 32'({cmd_vld, addr_vld, rx_vld, tx_req, frame_done}), 0);
    chk("rst_bytecnt", 32'(byte_cnt), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    #200;
    chk("post_rst_quiet", 32'(n_fd + n_busy + n_cmd), 0);

    // Directed write: 01 / aabbcc / 5 x aa
    b_cmd = n_cmd; b_addr = n_addr; b_rx = n_rx; b_tx = n_txreq; b_fd = n_fd;
    fill_wr(5, 1'b1, 8'haa);
    spi_frame(8'h01, 24'haabbcc, 5, -1, -1);
    #100;
    chk("wr_ncmd", 32'(n_cmd - b_cmd), 1);
    chk("wr_cmd", 32'(cmd_log[b_cmd]), 32'h01);
    chk("wr_naddr", 32'(n_addr - b_addr), 1);
    chk("wr_addr", 32'(addr_log[b_addr]), 32'haabbcc);
    chk("wr_nrx", 32'(n_rx - b_rx), 5);
    chk_rx("wr_rx", b_rx, 5);
    chk("wr_bytecnt", 32'(byte_cnt), 5);
    chk("wr_ntxreq", 32'(n_txreq - b_tx), 0);
    chk("wr_nfd", 32'(n_fd - b_fd), 1);
    chk("wr_idle", 32'({busy, spi_sdo_oe}), 0);

    // Directed read: 03 / 000010, user returns 5A then C3
    tbase = tx_rd_idx;
    tx_src[tbase] = 8'h5a; tx_src[tbase+1] = 8'hc3;
    b_rx = n_rx; b_tx = n_txreq; b_both = n_both;
    fill_wr(2, 1'b0, 8'h00);
    spi_frame(8'h03, 24'h000010, 2, -1, -1);
    #100;
    v = '0;
    for (int k = 0; k < 16; k++) v = {v[30:0], sdo_log[32+k]};
    chk("rd_sdo", v, 32'h5ac3);
    v = '0;
    for (int k = 0; k < 32; k++) v = {v[30:0], sdo_log[k]};
    chk("rd_sdo_hdr", v, 0);
    chk("rd_ntxreq", 32'(n_txreq - b_tx), 3);
    chk("rd_txreq_with_addr", 32'(n_both - b_both), 1);
    chk("rd_nrx", 32'(n_rx - b_rx), 0);
    chk("rd_addr", 32'(addr), 32'h000010);
    chk("rd_bytecnt", 32'(byte_cnt), 2);

    // Random read, 3 bytes
    tbase = tx_rd_idx;
    for (int j = 0; j < 4; j++) tx_src[tbase+j] = 8'($urandom_range(0, 255));
    a = 24'($urandom);
    fill_wr(3, 1'b0, 8'h00);
    spi_frame(8'h03, a, 3, -1, -1);
    #100;
    for (int j = 0; j < 3; j++) begin
      v = '0;
      for (int k = 0; k < 8; k++) v = {v[30:0], sdo_log[32+8*j+k]};
      chk("rrd_sdo", v, 32'(tx_src[tbase+j]));
    end
    chk("rrd_addr", 32'(addr), 32'(a));

    // Abort after 12 address bits
    b_cmd = n_cmd; b_addr = n_addr; b_fd = n_fd;
    spi_frame(8'h01, 24'hfedcba, 0, 20, -1);
    #100;
    chk("ab_ncmd", 32'(n_cmd - b_cmd), 1);
    chk("ab_naddr", 32'(n_addr - b_addr), 0);
    chk("ab_nfd", 32'(n_fd - b_fd), 1);
    chk("ab_idle", 32'({busy, spi_sdo_oe}), 0);
    chk("ab_addr_held", 32'(addr), 32'(a));
    b_rx = n_rx;
    fill_wr(2, 1'b0, 8'h00);
    spi_frame(8'h01, 24'h123456, 2, -1, -1);
    #100;
    chk("ab2_cmd", 32'(cmd), 32'h01);
    chk("ab2_addr", 32'(addr), 32'h123456);
    chk_rx("ab2_rx", b_rx, 2);

    // Reset mid-frame during data byte 2 (bit 3 of byte index 1)
    c = 8'($urandom_range(4, 255)); a = 24'($urandom);
    b_cmd = n_cmd; b_addr = n_addr; b_rx = n_rx; b_fd = n_fd; b_busy = n_busy;
    fill_wr(4, 1'b0, 8'h00);
    spi_frame(c, a, 4, -1, 43);
    #100;
    chk("mr_ncmd", 32'(n_cmd - b_cmd), 1);
    chk("mr_naddr", 32'(n_addr - b_addr), 1);
    chk("mr_nrx", 32'(n_rx - b_rx), 1);
    chk("mr_nfd", 32'(n_fd - b_fd), 0);
    chk("mr_cleared", {cmd, addr}, 0);
    chk("mr_rx_bc", 32'({rx_data, byte_cnt}), 0);
    chk("mr_idle", 32'({busy, spi_sdo_oe, spi_sdo}), 0);
    c = 8'($urandom_range(4, 255)); a = 24'($urandom); b_rx = n_rx;
    fill_wr(3, 1'b0, 8'h00);
    spi_frame(c, a, 3, -1, -1);
    #100;
    chk("mr2_cmd", 32'(cmd), 32'(c));
    chk("mr2_addr", 32'(addr), 32'(a));
    chk_rx("mr2_rx", b_rx, 3);
    chk("mr2_bytecnt", 32'(byte_cnt), 3);

    // Back-to-back writes, CS high for 4 clk between
    c = 8'h10; a = 24'($urandom); c2 = 8'h22; a2 = 24'($urandom);
    b_cmd = n_cmd; b_addr = n_addr; b_fd = n_fd; b_rx = n_rx;
    nb = 1 + int'($urandom_range(0, 3));
    fill_wr(nb, 1'b0, 8'h00);
    spi_frame(c, a, nb, -1, -1);
    chk_rx("bb1_rx", b_rx, nb);
    b_rx = n_rx;
    fill_wr(2, 1'b0, 8'h00);
    spi_frame(c2, a2, 2, -1, -1);
    #100;
    chk("bb_ncmd", 32'(n_cmd - b_cmd), 2);
    chk("bb1_cmd", 32'(cmd_log[b_cmd]), 32'(c));
    chk("bb1_addr", 32'(addr_log[b_addr]), 32'(a));
    chk("bb2_cmd", 32'(cmd_log[b_cmd+1]), 32'(c2));
    chk("bb2_addr", 32'(addr_log[b_addr+1]), 32'(a2));
    chk("bb2_bc_restart", 32'(bc_log[b_cmd+1]), 0);
    chk_rx("bb2_rx", b_rx, 2);
    chk("bb2_bytecnt", 32'(byte_cnt), 2);
    chk("bb_nfd", 32'(n_fd - b_fd), 2);

    // SCK glitching with CS high
    b_cmd = n_cmd; b_addr = n_addr; b_rx = n_rx; b_tx = n_txreq; b_fd = n_fd; b_busy = n_busy;
    for (int i = 0; i < 20; i++) begin
      spi_sdi = 1'($urandom_range(0, 1));
      #(10 * $urandom_range(1, 6)) spi_sck = ~spi_sck;
    end
    spi_sck = 1'b0;
    #100;
    chk("gl_pulses", 32'((n_cmd - b_cmd) + (n_addr - b_addr) + (n_rx - b_rx) + (n_txreq - b_tx)), 0);
    chk("gl_nfd", 32'(n_fd - b_fd), 0);
    chk("gl_busy", 32'(n_busy - b_busy), 0);
    chk("gl_bytecnt", 32'(byte_cnt), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
